// File: rtl/fetch_sequencer.sv
// fetch_sequencer: registered instruction fetch with stall, redirect, halt.
// Define FETCH_PERF_EN to add saturating fetch/stall counter outputs.
module fetch_sequencer #(
    parameter logic [9:0]  RESET_PC   = 10'd0,
    parameter logic [31:0] HALT_INSTR = 32'h0000_0073
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [9:0]  pc_o,
    input  logic [31:0] instr_i,
    output logic [31:0] instr_o,
    output logic [9:0]  instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [9:0]  redirect_pc_i,
    output logic        halt_o
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] fetch_cnt_o,
    output logic [15:0] stall_cnt_o
`endif
);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [9:0]  pc_q;
    logic [9:0]  pc_d;
    logic [9:0]  ipc_q;
    logic [9:0]  ipc_d;
    logic [31:0] instr_q;
    logic [31:0] instr_d;
    logic        valid_q;
    logic        valid_d;

    logic slot_free;
    logic load;
    logic stall;
    logic is_halt;

    assign slot_free = !valid_q || instr_ready_i;
    assign is_halt   = (instr_i == HALT_INSTR);
    assign load      = !redirect_i && (state_q == FETCH) && slot_free;
    assign stall     = !redirect_i && valid_q && !instr_ready_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        unique case (1'b1)
            redirect_i: begin
                // The word on instr_i belongs to the squashed path.
                pc_d    = redirect_pc_i;
                valid_d = 1'b0;
                state_d = FETCH;
            end
            load: begin
                instr_d = instr_i;
                ipc_d   = pc_q;
                valid_d = 1'b1;
                if (is_halt) begin
                    state_d = HALT;
                end else begin
                    pc_d = pc_q + 10'd1;
                end
            end
            default: begin
                if (state_q == HALT && valid_q && instr_ready_i) begin
                    valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ipc_q   <= 10'd0;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o          = pc_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = ipc_q;
    assign instr_valid_o = valid_q;
    assign halt_o        = (state_q == HALT);

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt_q;
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_cnt_q <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            if (load && fetch_cnt_q != 16'hFFFF) begin
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end
            if (stall && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios plus a randomized scoreboard run.
// Define FETCH_PERF_EN to also exercise the performance counters.
module tb_fetch_sequencer;

    localparam logic [9:0]  RPC   = 10'd0;
    localparam logic [31:0] HALTW = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  pc_o;
    logic [31:0] instr_i;
    logic [31:0] instr_o;
    logic [9:0]  instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [9:0]  redirect_pc_i;
    logic        halt_o;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt_o;
    logic [15:0] stall_cnt_o;
`endif

    logic [31:0] mem [1024];
    int n_checks = 0;
    int n_fail   = 0;

    assign instr_i = mem[pc_o];

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_PC  (RPC),
        .HALT_INSTR(HALTW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pc_o         (pc_o),
        .instr_i      (instr_i),
        .instr_o      (instr_o),
        .instr_pc_o   (instr_pc_o),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .halt_o       (halt_o)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt_o  (fetch_cnt_o),
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addi(int i);
        return {12'(i + 1), 5'd0, 3'b000, 5'd1, 7'h13};
    endfunction

    task automatic fill_addi();
        for (int i = 0; i < 1024; i++) mem[i] = addi(i);
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 10'd0;
        instr_ready_i = 1'b1;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        fill_addi();
        reset_n       = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 10'd25;
        instr_ready_i = 1'b1;
        step();
        redirect_i = 1'b0;
        n_checks++;
        if (pc_o !== RPC) begin
            n_fail++;
            $display("FAIL reset_pc: got %0d want %0d", pc_o, RPC);
        end
        n_checks++;
        if (instr_o !== 32'd0 || instr_pc_o !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_instr: got %h/%0d want 0/0",
                     instr_o, instr_pc_o);
        end
        n_checks++;
        if (instr_valid_o !== 1'b0 || halt_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got v=%b h=%b want 0/0",
                     instr_valid_o, halt_o);
        end
        // reset while stalled
        reset_n       = 1'b1;
        instr_ready_i = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        step();
        n_checks++;
        if (instr_valid_o !== 1'b0 || pc_o !== RPC) begin
            n_fail++;
            $display("FAIL reset_stall: got v=%b pc=%0d want 0/%0d",
                     instr_valid_o, pc_o, RPC);
        end
        // reset while halted
        mem[1]        = HALTW;
        reset_n       = 1'b1;
        instr_ready_i = 1'b1;
        step();
        step();
        n_checks++;
        if (halt_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_halt: got %b want 1", halt_o);
        end
        reset_n = 1'b0;
        step();
        n_checks++;
        if (halt_o !== 1'b0 || instr_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_halt: got h=%b v=%b want 0/0",
                     halt_o, instr_valid_o);
        end
        mem[1] = addi(1);
    endtask

    task automatic test_sequential();
        fill_addi();
        do_reset();
        n_checks++;
        if (pc_o !== 10'd0) begin
            n_fail++;
            $display("FAIL seq_pc0: got %0d want 0", pc_o);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++;
            if (pc_o !== 10'(i) || instr_pc_o !== 10'(i - 1) ||
                instr_valid_o !== 1'b1 || instr_o !== mem[i - 1]) begin
                n_fail++;
                $display("FAIL seq_%0d: got pc=%0d ipc=%0d v=%b want %0d/%0d/1",
                         i, pc_o, instr_pc_o, instr_valid_o, i, i - 1);
            end
        end
    endtask

    task automatic test_stall();
        fill_addi();
        do_reset();
        for (int i = 0; i < 6; i++) step();
        n_checks++;
        if (instr_pc_o !== 10'd5 || pc_o !== 10'd6) begin
            n_fail++;
            $display("FAIL stall_pre: got ipc=%0d pc=%0d want 5/6",
                     instr_pc_o, pc_o);
        end
        instr_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (pc_o !== 10'd6 || instr_pc_o !== 10'd5 ||
                instr_o !== mem[5] || instr_valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got pc=%0d ipc=%0d v=%b want 6/5/1",
                         k, pc_o, instr_pc_o, instr_valid_o);
            end
        end
        instr_ready_i = 1'b1;
        step();
        n_checks++;
        if (instr_pc_o !== 10'd6 || instr_o !== mem[6] || pc_o !== 10'd7) begin
            n_fail++;
            $display("FAIL stall_release: got ipc=%0d pc=%0d want 6/7",
                     instr_pc_o, pc_o);
        end
    endtask

    task automatic test_redirect();
        fill_addi();
        do_reset();
        step();
        instr_ready_i = 1'b0;
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 10'd25;
        step();
        redirect_i = 1'b0;
        n_checks++;
        if (instr_valid_o !== 1'b0 || pc_o !== 10'd25) begin
            n_fail++;
            $display("FAIL redir_flush: got v=%b pc=%0d want 0/25",
                     instr_valid_o, pc_o);
        end
        step();
        n_checks++;
        if (instr_pc_o !== 10'd25 || instr_valid_o !== 1'b1 ||
            instr_o !== mem[25] || pc_o !== 10'd26) begin
            n_fail++;
            $display("FAIL redir_load: got ipc=%0d v=%b pc=%0d want 25/1/26",
                     instr_pc_o, instr_valid_o, pc_o);
        end
        // redirect coincident with an accept
        instr_ready_i = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 10'd100;
        step();
        redirect_i = 1'b0;
        n_checks++;
        if (instr_valid_o !== 1'b0 || pc_o !== 10'd100) begin
            n_fail++;
            $display("FAIL redir_accept: got v=%b pc=%0d want 0/100",
                     instr_valid_o, pc_o);
        end
        step();
        n_checks++;
        if (instr_pc_o !== 10'd100 || instr_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL redir_accept_load: got ipc=%0d v=%b want 100/1",
                     instr_pc_o, instr_valid_o);
        end
    endtask

    task automatic test_halt();
        fill_addi();
        mem[4] = HALTW;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (halt_o !== 1'b0 || instr_pc_o !== 10'd3) begin
            n_fail++;
            $display("FAIL halt_pre: got h=%b ipc=%0d want 0/3",
                     halt_o, instr_pc_o);
        end
        step();
        n_checks++;
        if (instr_pc_o !== 10'd4 || instr_valid_o !== 1'b1 ||
            halt_o !== 1'b1 || pc_o !== 10'd4 || instr_o !== HALTW) begin
            n_fail++;
            $display("FAIL halt_enter: got ipc=%0d v=%b h=%b pc=%0d want 4/1/1/4",
                     instr_pc_o, instr_valid_o, halt_o, pc_o);
        end
        instr_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks++;
            if (instr_valid_o !== 1'b1 || halt_o !== 1'b1 || pc_o !== 10'd4) begin
                n_fail++;
                $display("FAIL halt_pending%0d: got v=%b h=%b pc=%0d want 1/1/4",
                         k, instr_valid_o, halt_o, pc_o);
            end
        end
        instr_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (instr_valid_o !== 1'b0 || halt_o !== 1'b1 || pc_o !== 10'd4) begin
                n_fail++;
                $display("FAIL halt_idle%0d: got v=%b h=%b pc=%0d want 0/1/4",
                         k, instr_valid_o, halt_o, pc_o);
            end
        end
        redirect_i    = 1'b1;
        redirect_pc_i = 10'd0;
        step();
        redirect_i = 1'b0;
        n_checks++;
        if (halt_o !== 1'b0 || pc_o !== 10'd0 || instr_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_exit: got h=%b pc=%0d v=%b want 0/0/0",
                     halt_o, pc_o, instr_valid_o);
        end
        mem[4] = addi(4);
    endtask

    task automatic test_wrap();
        fill_addi();
        do_reset();
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 10'd1023;
        step();
        redirect_i = 1'b0;
        n_checks++;
        if (pc_o !== 10'd1023 || instr_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_target: got pc=%0d v=%b want 1023/0",
                     pc_o, instr_valid_o);
        end
        step();
        n_checks++;
        if (pc_o !== 10'd0 || instr_pc_o !== 10'd1023 || instr_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_0: got pc=%0d ipc=%0d want 0/1023",
                     pc_o, instr_pc_o);
        end
        step();
        n_checks++;
        if (pc_o !== 10'd1 || instr_pc_o !== 10'd0) begin
            n_fail++;
            $display("FAIL wrap_1: got pc=%0d ipc=%0d want 1/0",
                     pc_o, instr_pc_o);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        fill_addi();
        do_reset();
        n_checks++;
        if (fetch_cnt_o !== 16'd0 || stall_cnt_o !== 16'd0) begin
            n_fail++;
            $display("FAIL perf_reset: got %0d/%0d want 0/0",
                     fetch_cnt_o, stall_cnt_o);
        end
        for (int i = 0; i < 5; i++) step();
        instr_ready_i = 1'b0;
        step();
        step();
        n_checks++;
        if (fetch_cnt_o !== 16'd5 || stall_cnt_o !== 16'd2) begin
            n_fail++;
            $display("FAIL perf_count: got %0d/%0d want 5/2",
                     fetch_cnt_o, stall_cnt_o);
        end
        reset_n = 1'b0;
        step();
        n_checks++;
        if (fetch_cnt_o !== 16'd0 || stall_cnt_o !== 16'd0) begin
            n_fail++;
            $display("FAIL perf_clear: got %0d/%0d want 0/0",
                     fetch_cnt_o, stall_cnt_o);
        end
        reset_n       = 1'b1;
        instr_ready_i = 1'b1;
    endtask
`endif

    // Scoreboard: accepted words must form the in-order stream
    // starting at the last reset/redirect target, read from mem.
    task automatic test_random();
        logic [9:0]  exp_addr;
        logic        p_rst;
        logic        p_valid;
        logic        p_ready;
        logic        p_redir;
        logic [9:0]  p_rpc;
        logic [9:0]  p_pc;
        logic [9:0]  p_ipc;
        logic [31:0] p_instr;
        logic        p_halt;
        logic [31:0] w;
        logic        w_halt;
        int          errs;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = ($urandom_range(0, 31) == 0) ? HALTW : $urandom();
            if (mem[i] == HALTW && i == 1023) mem[i] = addi(i);
        end
        do_reset();
        exp_addr = RPC;
        errs     = 0;
        for (int c = 0; c < 4000; c++) begin
            reset_n       = ($urandom_range(0, 199) != 0);
            instr_ready_i = ($urandom_range(0, 9) < 7);
            redirect_i    = ($urandom_range(0, 24) == 0);
            redirect_pc_i = 10'($urandom_range(0, 1023));
            p_rst   = reset_n;
            p_valid = instr_valid_o;
            p_ready = instr_ready_i;
            p_redir = redirect_i;
            p_rpc   = redirect_pc_i;
            p_pc    = pc_o;
            p_ipc   = instr_pc_o;
            p_instr = instr_o;
            p_halt  = halt_o;
            if (p_rst && p_valid && p_ready) begin
                n_checks++;
                if (p_ipc !== exp_addr || p_instr !== mem[exp_addr]) begin
                    n_fail++;
                    if (errs++ < 10)
                        $display("FAIL rnd_accept c=%0d: got %0d:%h want %0d:%h",
                                 c, p_ipc, p_instr, exp_addr, mem[exp_addr]);
                end
                exp_addr = p_ipc + 10'd1;
            end
            if (!p_rst) exp_addr = RPC;
            else if (p_redir) exp_addr = p_rpc;
            step();
            n_checks++;
            if (!p_rst) begin
                if (pc_o !== RPC || instr_valid_o !== 1'b0 || halt_o !== 1'b0 ||
                    instr_o !== 32'd0 || instr_pc_o !== 10'd0) begin
                    n_fail++;
                    if (errs++ < 10)
                        $display("FAIL rnd_reset c=%0d: got pc=%0d v=%b h=%b want %0d/0/0",
                                 c, pc_o, instr_valid_o, halt_o, RPC);
                end
            end else if (p_redir) begin
                if (pc_o !== p_rpc || instr_valid_o !== 1'b0 || halt_o !== 1'b0) begin
                    n_fail++;
                    if (errs++ < 10)
                        $display("FAIL rnd_redirect c=%0d: got pc=%0d v=%b h=%b want %0d/0/0",
                                 c, pc_o, instr_valid_o, halt_o, p_rpc);
                end
            end else if (p_valid && !p_ready) begin
                if (pc_o !== p_pc || instr_pc_o !== p_ipc || instr_o !== p_instr ||
                    instr_valid_o !== 1'b1 || halt_o !== p_halt) begin
                    n_fail++;
                    if (errs++ < 10)
                        $display("FAIL rnd_stall c=%0d: got pc=%0d ipc=%0d want %0d/%0d",
                                 c, pc_o, instr_pc_o, p_pc, p_ipc);
                end
            end else if (p_halt) begin
                if (pc_o !== p_pc || instr_valid_o !== 1'b0 || halt_o !== 1'b1) begin
                    n_fail++;
                    if (errs++ < 10)
                        $display("FAIL rnd_halt c=%0d: got pc=%0d v=%b h=%b want %0d/0/1",
                                 c, pc_o, instr_valid_o, halt_o, p_pc);
                end
            end else begin
                w      = mem[p_pc];
                w_halt = (w == HALTW);
                if (instr_valid_o !== 1'b1 || instr_pc_o !== p_pc || instr_o !== w ||
                    halt_o !== w_halt ||
                    pc_o !== (w_halt ? p_pc : 10'(p_pc + 10'd1))) begin
                    n_fail++;
                    if (errs++ < 10)
                        $display("FAIL rnd_load c=%0d: got ipc=%0d pc=%0d h=%b want %0d/%0d/%b",
                                 c, instr_pc_o, pc_o, halt_o, p_pc,
                                 w_halt ? p_pc : 10'(p_pc + 10'd1), w_halt);
                end
            end
        end
        redirect_i = 1'b0;
        reset_n    = 1'b1;
    endtask

    initial begin
        reset_n       = 1'b0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 10'd0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 10'd0, word index of the first instruction fetched after reset.
REQ-002 Parameter HALT_INSTR, default 32'h0000_0073 (ECALL), encoding that halts sequencing.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset_n  input  1  reset; synchronous, active-low.
REQ-005 Port pc_o  output  10  word address driven to the instruction memory, registered.
REQ-006 Port instr_i  input  32  combinational read data from the instruction memory for pc_o.
REQ-007 Port instr_o  output  32  registered instruction presented to decode.
REQ-008 Port instr_pc_o  output  10  word address from which instr_o was fetched.
REQ-009 Port instr_valid_o  output  1  instr_o/instr_pc_o hold a valid instruction.
REQ-010 Port instr_ready_i  input  1  decode accepts instr_o this cycle when instr_valid_o is high.
REQ-011 Port redirect_i  input  1  branch/jump redirect request, one-cycle pulse.
REQ-012 Port redirect_pc_i  input  10  redirect target word address.
REQ-013 Port halt_o  output  1  sequencer is in HALT state.

Function
REQ-014 States: FETCH, HALT; reset enters FETCH.
REQ-015 Output slot "free" = !instr_valid_o or (instr_valid_o and instr_ready_i).
REQ-016 FETCH, slot free, no redirect: instr_o<=instr_i, instr_pc_o<=pc_o, instr_valid_o<=1, pc_o<=pc_o+1.
REQ-017 Latency: address on pc_o in cycle N -> matching instruction on instr_o with instr_valid_o=1 in cycle N+1.
REQ-018 pc_o increment is modulo 1024; 10'd1023 wraps to 10'd0 without any flag.
REQ-019 Stall (instr_valid_o=1, instr_ready_i=0, no redirect): pc_o, instr_o, instr_pc_o, instr_valid_o hold unchanged.
REQ-020 Redirect has highest priority in every state: next cycle pc_o=redirect_pc_i, instr_valid_o=0, state=FETCH, halt_o=0; instr_i that cycle is discarded.
REQ-021 Redirect in same cycle as an accept: the accept completes; no new instruction is loaded that cycle.
REQ-022 When instr_i==HALT_INSTR is loaded per REQ-016, state->HALT and pc_o is NOT incremented.
REQ-023 HALT: no loads, pc_o frozen; pending halt instruction stays valid until accepted, then instr_valid_o=0.
REQ-024 halt_o=1 exactly while state==HALT; exit only via redirect or reset.
REQ-025 At most one instruction is outstanding; no instruction is duplicated or dropped except by redirect flush.

Reset
REQ-026 reset_n=0 sampled at a rising edge: pc_o=RESET_PC, instr_o=0, instr_pc_o=0, instr_valid_o=0, halt_o=0, state=FETCH.
REQ-027 Reset mid-stall or mid-HALT discards the held instruction; reset overrides redirect.
REQ-028 First rising edge with reset_n=1 performs the load of mem[RESET_PC] per REQ-016.

Configuration
REQ-029 Macro FETCH_PERF_EN defined: adds outputs fetch_cnt_o[15:0] (increments per REQ-016 load) and stall_cnt_o[15:0] (increments per REQ-019 stall cycle), both saturating at 16'hFFFF and cleared by reset.
REQ-030 Macro FETCH_PERF_EN undefined: counters and their ports are absent; all other behaviour identical.

Verification
REQ-031 Reset, ready=1 constant, mem[0..2]=addi words -> pc_o 0,1,2,3 on consecutive cycles; instr_pc_o 0,1,2 one cycle later, valid continuous.
REQ-032 ready=0 for 3 cycles while instr_pc_o=5 -> pc_o stays 6, instr_o unchanged 3 cycles; ready=1 -> instr_pc_o=6 next cycle.
REQ-033 redirect_i=1, redirect_pc_i=10'd25 while valid and stalled -> next cycle valid=0, pc_o=25; following cycle instr_pc_o=25.
REQ-034 mem[4]=32'h0000_0073, ready=1 -> instr_pc_o=4 valid once, halt_o=1, pc_o frozen at 4, valid=0 after accept; redirect to 0 clears halt_o.
REQ-035 redirect to 10'd1023 -> pc_o sequence 1023, 0, 1; instr_pc_o 1023 then 0.
REQ-036 With FETCH_PERF_EN: 5 loads and 2 stall cycles after reset -> fetch_cnt_o=5, stall_cnt_o=2; reset_n=0 mid-run -> both 0 next cycle.
